// File: rtl/instr_encoder.sv
// instr_encoder: packs field bundles into 17-bit instruction words, buffers
// them in a DEPTH-entry FIFO and emits them with sequential write addresses.
// Ports: clk, reset (sync, active-high), start; in_* valid/ready bundle
// (type, sel, op, operand, last); out_* valid/ready word + address; err, done.
// Option: define ENC_STRICT_EN to drop illegal bundles and pulse err.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic              in_sel,
  input  logic [2:0]        in_op,
  input  logic [10:0]       in_operand,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [16:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic              done
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    FIN
  } state_t;

  state_t            state_q;
  logic [17:0]       mem_q [DEPTH];
  logic [PW-1:0]     rd_q;
  logic [PW-1:0]     wr_q;
  logic [PW:0]       cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              err_q;
  logic              err_d;
  logic [16:0]       word;
  logic              accept;
  logic              push;
  logic              pop;
  logic              head_last;

  // Branch/reserved layout is the raw field concatenation;
  // data and memory force their unused bits to zero.
  always_comb begin
    word = {in_type, in_sel, in_op, in_operand};
    unique case (in_type)
      2'b00:   word[13:11] = {in_op[1:0], 1'b0};
      2'b01:   word[14:11] = {2'b00, in_op[0], 1'b0};
      default: word[13:11] = in_op;
    endcase
  end

  assign in_ready  = (state_q == LOAD) && (cnt_q != FULL);
  assign accept    = in_valid && in_ready;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign head_last = mem_q[rd_q][0];
  assign out_instr = out_valid ? mem_q[rd_q][17:1] : '0;
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign done      = done_q;

`ifdef ENC_STRICT_EN
  logic illegal;

  always_comb begin
    unique case (in_type)
      2'b00:   illegal = in_op[2];
      2'b01:   illegal = in_sel | (in_op[2:1] != 2'b00);
      2'b10:   illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  assign push  = accept && !illegal;
  assign err_d = accept && illegal;
`else
  assign push  = accept;
  assign err_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {word, in_last};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q   <= rd_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            addr_q  <= '0;
            done_q  <= 1'b0;
          end
        end
        LOAD: begin
          // an illegal last bundle still closes the program
          if (accept && in_last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // empty FIFO covers a dropped illegal last bundle
          if ((pop && head_last) || (cnt_q == '0)) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          if (start) begin
            state_q <= LOAD;
            addr_q  <= '0;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
